// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster pixel stream to registered 3x3 neighbourhoods, flagging only fully in-image windows
module window_3x3_gen #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int DATA_W = 8,
   localparam int CW = $clog2(IMG_W),
   localparam int RW = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   input  logic              sof,
   output logic [DATA_W-1:0] p1,
   output logic [DATA_W-1:0] p2,
   output logic [DATA_W-1:0] p3,
   output logic [DATA_W-1:0] p4,
   output logic [DATA_W-1:0] p5,
   output logic [DATA_W-1:0] p6,
   output logic [DATA_W-1:0] p7,
   output logic [DATA_W-1:0] p8,
   output logic [DATA_W-1:0] p9,
   output logic              win_valid,
   output logic [RW-1:0]     row_o,
   output logic [CW-1:0]     col_o,
   output logic              window_strobe
);
   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [CW-1:0] col, c;
   logic [RW-1:0] row, r;
   logic [DATA_W-1:0] top, mid;
   logic in_img;
   // sof relocates the accepted pixel to (0,0) regardless of the running count
   always_comb begin
      c = sof ? '0 : col;
      r = sof ? '0 : row;
      top = lb0[c];
      mid = lb1[c];
      in_img = (r >= RW'(2)) && (c >= CW'(2));
   end
   always_ff @(posedge clk) begin
      if (pix_valid && !rst) begin
         lb1[c] <= pix_in;
         lb0[c] <= lb1[c];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
         {p1, p2, p3, p4, p5, p6, p7, p8, p9} <= '0;
         win_valid <= 1'b0;
         row_o <= '0;
         col_o <= '0;
         window_strobe <= 1'b0;
      end else begin
         window_strobe <= pix_valid & in_img;
         if (pix_valid) begin
            col <= (c == CW'(IMG_W - 1)) ? '0 : c + 1'b1;
            row <= (c != CW'(IMG_W - 1)) ? r : (r == RW'(IMG_H - 1)) ? '0 : r + 1'b1;
            {p1, p2, p3} <= {p2, p3, top};
            {p4, p5, p6} <= {p5, p6, mid};
            {p7, p8, p9} <= {p8, p9, pix_in};
            win_valid <= in_img;
            row_o <= r;
            col_o <= c;
         end
      end
   end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: directed table-driven checks of window_3x3_gen on 4x4 and 3x3 images
module tb_window_3x3_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, pv, sof;
   logic [7:0] pix;
   logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic wv, ws;
   logic [1:0] ro, co;

   logic rst3, pv3, sof3;
   logic [7:0] pix3;
   logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
   logic wv3, ws3;
   logic [1:0] ro3, co3;

   window_3x3_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u4 (
      .clk(clk), .rst(rst), .pix_in(pix), .pix_valid(pv), .sof(sof),
      .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
      .win_valid(wv), .row_o(ro), .col_o(co), .window_strobe(ws));

   window_3x3_gen #(.IMG_W(3), .IMG_H(3), .DATA_W(8)) u3 (
      .clk(clk), .rst(rst3), .pix_in(pix3), .pix_valid(pv3), .sof(sof3),
      .p1(a1), .p2(a2), .p3(a3), .p4(a4), .p5(a5), .p6(a6), .p7(a7), .p8(a8), .p9(a9),
      .win_valid(wv3), .row_o(ro3), .col_o(co3), .window_strobe(ws3));

   logic [7:0] cur [9];
   logic [7:0] cur3 [9];
   always_comb begin
      cur = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
      cur3 = '{a1, a2, a3, a4, a5, a6, a7, a8, a9};
   end

   typedef struct {
      logic [7:0] pix;
      logic       wv;
      int         row;
      int         col;
      logic [7:0] w [9];
   } vec_t;
   vec_t tab [16];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic s, input logic x, input logic [7:0] d);
      pv = v;
      sof = s;
      rst = x;
      pix = d;
      @(posedge clk);
      #1;
   endtask

   task automatic step3(input logic v, input logic s, input logic x, input logic [7:0] d);
      pv3 = v;
      sof3 = s;
      rst3 = x;
      pix3 = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " wv"}, wv, 0);
      chk({tag, " ws"}, ws, 0);
      chk({tag, " row"}, ro, 0);
      chk({tag, " col"}, co, 0);
      for (int k = 0; k < 9; k++) chk($sformatf("%s p%0d", tag, k + 1), cur[k], 0);
   endtask

   task automatic run_frame(input string tag, input int base, input logic first_sof, input logic gaps);
      int strobes;
      logic [7:0] h5;
      strobes = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, first_sof && i == 0, 1'b0, 8'(tab[i].pix + base));
         strobes += int'(ws);
         chk($sformatf("%s[%0d] wv", tag, i), wv, tab[i].wv);
         chk($sformatf("%s[%0d] ws", tag, i), ws, tab[i].wv);
         chk($sformatf("%s[%0d] row", tag, i), ro, tab[i].row);
         chk($sformatf("%s[%0d] col", tag, i), co, tab[i].col);
         chk($sformatf("%s[%0d] p9", tag, i), p9, 8'(tab[i].pix + base));
         if (tab[i].wv)
            for (int k = 0; k < 9; k++)
               chk($sformatf("%s[%0d] p%0d", tag, i, k + 1), cur[k], 8'(tab[i].w[k] + base));
         if (gaps) begin
            h5 = 8'(tab[i].wv ? tab[i].w[4] + base : 0);
            step(1'b0, 1'b0, 1'b0, 8'hEE);
            strobes += int'(ws);
            chk($sformatf("%s gap[%0d] ws", tag, i), ws, 0);
            chk($sformatf("%s gap[%0d] wv", tag, i), wv, tab[i].wv);
            chk($sformatf("%s gap[%0d] p9", tag, i), p9, 8'(tab[i].pix + base));
            if (tab[i].wv) chk($sformatf("%s gap[%0d] p5", tag, i), p5, h5);
         end
      end
      chk({tag, " strobes"}, strobes, 4);
   endtask

   initial begin
      int s3;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            tab[4*r+c].pix = 8'(4*r + c + 1);
            tab[4*r+c].wv = (r >= 2) && (c >= 2);
            tab[4*r+c].row = r;
            tab[4*r+c].col = c;
            for (int k = 0; k < 9; k++)
               tab[4*r+c].w[k] = (r >= 2 && c >= 2) ? 8'(4*(r - 2 + k/3) + (c - 2 + k%3) + 1) : 8'd0;
         end

      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b1, 1'b1, 8'h5A);
      chk_zero("reset");

      run_frame("frameA", 0, 1'b1, 1'b0);
      run_frame("frameB", 100, 1'b0, 1'b0);
      run_frame("gaps", 0, 1'b1, 1'b1);

      for (int i = 0; i < 6; i++) begin
         step(1'b1, i == 0, 1'b0, 8'(50 + i));
         chk($sformatf("pre-resync[%0d] wv", i), wv, 0);
      end
      chk("pre-resync row", ro, 1);
      chk("pre-resync col", co, 1);
      run_frame("resync", 0, 1'b1, 1'b0);

      for (int i = 0; i < 10; i++) step(1'b1, i == 0, 1'b0, tab[i].pix);
      chk("pre-rst row", ro, 2);
      chk("pre-rst col", co, 1);
      step(1'b1, 1'b1, 1'b1, 8'h77);
      chk_zero("midrst");
      run_frame("postrst", 0, 1'b0, 1'b0);

      step3(1'b0, 1'b0, 1'b1, 8'h00);
      chk("min reset wv", wv3, 0);
      s3 = 0;
      for (int i = 0; i < 9; i++) begin
         step3(1'b1, i == 0, 1'b0, 8'(i + 1));
         s3 += int'(ws3);
         chk($sformatf("min[%0d] wv", i), wv3, i == 8);
      end
      chk("min strobes", s3, 1);
      chk("min row", ro3, 2);
      chk("min col", co3, 2);
      for (int k = 0; k < 9; k++) chk($sformatf("min p%0d", k + 1), cur3[k], k + 1);
      step3(1'b0, 1'b0, 1'b0, 8'h00);
      chk("min hold wv", wv3, 1);
      chk("min hold ws", ws3, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
